stopwatch_ctrl: RTL

Control sequencer for the stopwatch seconds/minutes counter. It turns debounced single-cycle button events into a run/pause/split/clear state machine. It owns the tick prescaler, so it issues the counter's count-enable and clear strobes. It also selects whether the display shows the live time or a frozen split (lap) value. It sits between the debouncers/edge detectors and the counter/display path, in the fast clock domain.

---
 rtl/stopwatch_ctrl_if.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// Module      : stopwatch_ctrl_if
// Description : Button events, live time and control/display outputs of the
//               stopwatch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;
    logic        ss_pulse;
    logic        lap_pulse;
    logic        clr_pulse;
    logic [11:0] time_in;
    logic        count_en;
    logic        count_clr;
    logic [11:0] disp_time;
    logic        disp_frozen;
    logic [1:0]  state;
    logic [3:0]  lap_count;

    modport master (
        output ss_pulse, lap_pulse, clr_pulse, time_in,
        input  count_en, count_clr, disp_time, disp_frozen, state, lap_count
    );

    modport slave (
        input  ss_pulse, lap_pulse, clr_pulse, time_in,
        output count_en, count_clr, disp_time, disp_frozen, state, lap_count
    );
endinterface

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run/pause/split/clear sequencer with tick prescaler.
//               Optional split auto-release: STOPWATCH_SPLIT_AUTORELEASE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int TICK_W     = 27,
    parameter int HOLD_TICKS = 5
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_SPLIT = 2'b11
    } state_t;

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    state_t            state_q,     state_d;
    logic [TICK_W-1:0] presc_q,     presc_d;
    logic [11:0]       lap_reg_q,   lap_reg_d;
    logic [3:0]        lap_count_q, lap_count_d;
    logic              count_en_q,  count_en_d;
    logic              count_clr_q, count_clr_d;
    logic              running;
    logic              wrap;

`ifdef STOPWATCH_SPLIT_AUTORELEASE_EN
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`else
    // HOLD_TICKS only has meaning when auto-release is built in.
    logic [31:0] unused_hold;
    assign unused_hold = HOLD_TICKS;
`endif

    assign running = (state_q == ST_RUN) || (state_q == ST_SPLIT);
    assign wrap    = running && (presc_q == TICK_MAX);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        lap_reg_d   = lap_reg_q;
        lap_count_d = lap_count_q;
        count_en_d  = 1'b0;
        count_clr_d = 1'b0;
`ifdef STOPWATCH_SPLIT_AUTORELEASE_EN
        hold_d      = hold_q;
`endif
        if (running) begin
            presc_d = wrap ? '0 : presc_q + TICK_W'(1);
        end

        if (bus.clr_pulse) begin
            // Clear wins over everything, including a coincident tick.
            state_d     = ST_IDLE;
            presc_d     = '0;
            lap_reg_d   = '0;
            lap_count_d = '0;
            count_clr_d = 1'b1;
`ifdef STOPWATCH_SPLIT_AUTORELEASE_EN
            hold_d      = '0;
`endif
        end else begin
            count_en_d = wrap;
            if (bus.ss_pulse) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    ST_SPLIT: state_d = ST_PAUSE;
                    default:  state_d = ST_IDLE;
                endcase
            end else if (bus.lap_pulse) begin
                if (state_q == ST_RUN) begin
                    state_d   = ST_SPLIT;
                    lap_reg_d = bus.time_in;
                    if (lap_count_q != 4'hF) begin
                        lap_count_d = lap_count_q + 4'd1;
                    end
`ifdef STOPWATCH_SPLIT_AUTORELEASE_EN
                    hold_d = '0;
`endif
                end else if (state_q == ST_SPLIT) begin
                    state_d = ST_RUN;
                end
            end
`ifdef STOPWATCH_SPLIT_AUTORELEASE_EN
            else if ((state_q == ST_SPLIT) && count_en_q) begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            lap_reg_q   <= '0;
            lap_count_q <= '0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
`ifdef STOPWATCH_SPLIT_AUTORELEASE_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lap_reg_q   <= lap_reg_d;
            lap_count_q <= lap_count_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
`ifdef STOPWATCH_SPLIT_AUTORELEASE_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign bus.state       = state_q;
    assign bus.count_en    = count_en_q;
    assign bus.count_clr   = count_clr_q;
    assign bus.lap_count   = lap_count_q;
    assign bus.disp_frozen = (state_q == ST_SPLIT);
    assign bus.disp_time   = (state_q == ST_SPLIT) ? lap_reg_q : bus.time_in;

endmodule

`default_nettype wire
